// File: rtl/multi_phase_timer.sv
// Multi-phase down-counting timer: a prescaler produces ticks, and each phase
// counts down its programmed duration before the block advances cyclically to the next phase.
module multi_phase_timer #(
  parameter int CLK_PER_TICK = 50,
  parameter int NUM_PHASES   = 3,
  parameter int CNT_W        = 7,
  parameter int PH_W         = $clog2(NUM_PHASES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        hold,
  input  logic                        restart,
  input  logic [NUM_PHASES*CNT_W-1:0] dur_i,
  output logic                        tick_o,
  output logic [PH_W-1:0]             phase_o,
  output logic [CNT_W-1:0]            count_o,
  output logic                        last_o,
  output logic                        pre_last_o,
  output logic                        phase_done_o,
  output logic                        cycle_done_o,
  output logic                        busy_o
);

  localparam int PS_W = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  localparam logic [PS_W-1:0] PS_MAX  = PS_W'(CLK_PER_TICK - 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(NUM_PHASES - 1);

  logic [1:0]       state_q, state_d;
  logic [PS_W-1:0]  presc_q, presc_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             phase_done_q, phase_done_d;
  logic             cycle_done_q, cycle_done_d;
  logic [PH_W-1:0]  next_ph_s;
  logic             run_step_s;
  logic             active_s;

  // A zero duration is treated as one tick, so the load value never underflows.
  function automatic logic [CNT_W-1:0] load_val(input logic [NUM_PHASES*CNT_W-1:0] dur,
                                                input logic [PH_W-1:0] p);
    logic [CNT_W-1:0] d;
    d = dur[int'(p)*CNT_W +: CNT_W];
    if (d == '0) begin
      return '0;
    end else begin
      return d - CNT_W'(1);
    end
  endfunction

  // Compute the next state, the prescaler/phase/count updates and the boundary pulses.
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    phase_d      = phase_q;
    count_d      = count_q;
    tick_d       = 1'b0;
    phase_done_d = 1'b0;
    cycle_done_d = 1'b0;
    run_step_s   = 1'b0;
    next_ph_s    = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);

    if (!en) begin
      state_d = S_IDLE;
      presc_d = '0;
      phase_d = '0;
      count_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_RUN;
          presc_d = '0;
          phase_d = '0;
          count_d = load_val(dur_i, '0);
        end
        S_RUN: begin
          if (restart) begin
            presc_d = '0;
            phase_d = '0;
            count_d = load_val(dur_i, '0);
          end else if (hold) begin
            state_d = S_PAUSE;
          end else begin
            run_step_s = 1'b1;
          end
        end
        S_PAUSE: begin
          if (restart) begin
            state_d = hold ? S_PAUSE : S_RUN;
            presc_d = '0;
            phase_d = '0;
            count_d = load_val(dur_i, '0);
          end else if (hold) begin
            state_d = S_PAUSE;
          end else begin
            // The release cycle already counts as a running cycle.
            state_d    = S_RUN;
            run_step_s = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          presc_d = '0;
          phase_d = '0;
          count_d = '0;
        end
      endcase
    end

    if (run_step_s) begin
      if (presc_q == PS_MAX) begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (count_q == '0) begin
          phase_done_d = 1'b1;
          cycle_done_d = (phase_q == PH_LAST);
          phase_d      = next_ph_s;
          count_d      = load_val(dur_i, next_ph_s);
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end else begin
        presc_d = presc_q + PS_W'(1);
      end
    end else begin
      presc_d = presc_d;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      phase_q      <= '0;
      count_q      <= '0;
      tick_q       <= 1'b0;
      phase_done_q <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      phase_q      <= phase_d;
      count_q      <= count_d;
      tick_q       <= tick_d;
      phase_done_q <= phase_done_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign active_s     = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign busy_o       = active_s;
  assign tick_o       = tick_q;
  assign phase_o      = phase_q;
  assign count_o      = count_q;
  assign phase_done_o = phase_done_q;
  assign cycle_done_o = cycle_done_q;
  assign last_o       = active_s && (count_q == '0);
  assign pre_last_o   = active_s && (count_q == CNT_W'(1));

endmodule

// File: tb/tb_multi_phase_timer.sv
// Directed bench for multi_phase_timer: one instance with a 4-cycle tick and
// one with a 1-cycle tick, checked with immediate assertions at the negative clock edge.
module tb_multi_phase_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, hold, restart;
  logic [20:0] dur;
  logic        tick, last, pre_last, phase_done, cycle_done, busy;
  logic [1:0]  phase;
  logic [6:0]  count;

  logic        en1;
  logic [20:0] dur1;
  logic        tick1, last1, pre_last1, phase_done1, cycle_done1, busy1;
  logic [1:0]  phase1;
  logic [6:0]  count1;

  int errors = 0;
  int checks = 0;
  int n;
  int bad;

  always #5 clk = ~clk;

  multi_phase_timer #(.CLK_PER_TICK(4), .NUM_PHASES(3), .CNT_W(7)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hold(hold), .restart(restart), .dur_i(dur),
    .tick_o(tick), .phase_o(phase), .count_o(count), .last_o(last), .pre_last_o(pre_last),
    .phase_done_o(phase_done), .cycle_done_o(cycle_done), .busy_o(busy)
  );

  multi_phase_timer #(.CLK_PER_TICK(1), .NUM_PHASES(3), .CNT_W(7)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .hold(1'b0), .restart(1'b0), .dur_i(dur1),
    .tick_o(tick1), .phase_o(phase1), .count_o(count1), .last_o(last1), .pre_last_o(pre_last1),
    .phase_done_o(phase_done1), .cycle_done_o(cycle_done1), .busy_o(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance until phase_done is seen at a negedge, bounded by max cycles.
  task automatic wait_pd(input int max, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!phase_done && cnt < max);
    chk("pd_seen", 32'(phase_done), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; hold = 1'b0; restart = 1'b0;
    en1 = 1'b0;
    dur  = {7'd5, 7'd2, 7'd3};
    dur1 = {7'd1, 7'd1, 7'd1};
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_last",  32'(last),  32'd0);
    chk("rst_pulses", 32'({tick, phase_done, cycle_done}), 32'd0);

    // Basic sequence: 3/2/5 ticks of 4 cycles each.
    rst_n = 1'b1; en = 1'b1;
    @(negedge clk);
    chk("start_count", 32'(count), 32'd2);
    chk("start_busy",  32'(busy),  32'd1);
    chk("start_pre",   32'(pre_last), 32'd0);
    repeat (3) @(negedge clk);
    chk("hold4_count", 32'(count), 32'd2);
    chk("hold4_tick",  32'(tick),  32'd0);
    @(negedge clk);
    chk("tick1_count", 32'(count), 32'd1);
    chk("tick1_tick",  32'(tick),  32'd1);
    chk("tick1_pre",   32'(pre_last), 32'd1);
    wait_pd(20, n);
    chk("p0_len",   32'(n), 32'd8);
    chk("p1_phase", 32'(phase), 32'd1);
    chk("p1_count", 32'(count), 32'd1);
    chk("p1_cd",    32'(cycle_done), 32'd0);
    wait_pd(20, n);
    chk("p1_len",   32'(n), 32'd8);
    chk("p2_phase", 32'(phase), 32'd2);
    chk("p2_count", 32'(count), 32'd4);
    wait_pd(40, n);
    chk("p2_len",   32'(n), 32'd20);
    chk("wrap_phase", 32'(phase), 32'd0);
    chk("wrap_count", 32'(count), 32'd2);
    chk("wrap_cd",    32'(cycle_done), 32'd1);

    // Pause for 7 cycles in phase 1.
    wait_pd(20, n);
    chk("p0b_len", 32'(n), 32'd12);
    repeat (2) @(negedge clk);
    hold = 1'b1;
    bad = 0;
    repeat (7) begin
      @(negedge clk);
      if (tick || count != 7'd1 || phase != 2'd1 || !busy) bad++;
    end
    chk("pause_frozen", 32'(bad), 32'd0);
    hold = 1'b0;
    wait_pd(20, n);
    chk("pause_len",  32'(n), 32'd6);
    chk("pause_phase", 32'(phase), 32'd2);

    // Restart in phase 2 with count 3, mid-prescale.
    repeat (4) @(negedge clk);
    chk("pre_rs_count", 32'(count), 32'd3);
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("rs_phase", 32'(phase), 32'd0);
    chk("rs_count", 32'(count), 32'd2);
    chk("rs_pulses", 32'({tick, phase_done, cycle_done}), 32'd0);
    repeat (3) @(negedge clk);
    chk("rs_presc_count", 32'(count), 32'd2);
    @(negedge clk);
    chk("rs_presc_tick", 32'(tick), 32'd1);
    chk("rs_presc_cnt1", 32'(count), 32'd1);

    // Restart coincident with the tick that would end phase 0.
    repeat (7) @(negedge clk);
    chk("pre_rs2_count", 32'(count), 32'd0);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("rs2_phase", 32'(phase), 32'd0);
    chk("rs2_count", 32'(count), 32'd2);
    chk("rs2_pulses", 32'({tick, phase_done, cycle_done}), 32'd0);

    // Zero duration for phase 1 behaves as a single tick.
    dur = {7'd5, 7'd0, 7'd3};
    wait_pd(20, n);
    chk("z_p0_len", 32'(n), 32'd12);
    chk("z_phase",  32'(phase), 32'd1);
    chk("z_count",  32'(count), 32'd0);
    bad = 0;
    repeat (3) begin
      if (!last || pre_last || phase != 2'd1) bad++;
      @(negedge clk);
    end
    if (!last || pre_last || phase != 2'd1) bad++;
    chk("z_flags", 32'(bad), 32'd0);
    @(negedge clk);
    chk("z_end_pd",    32'(phase_done), 32'd1);
    chk("z_end_phase", 32'(phase), 32'd2);

    // Synchronous abort via en, then restart from phase 0.
    repeat (2) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("abort_busy",  32'(busy),  32'd0);
    chk("abort_phase", 32'(phase), 32'd0);
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_last",  32'(last),  32'd0);
    en = 1'b1;
    @(negedge clk);
    chk("reen_phase", 32'(phase), 32'd0);
    chk("reen_count", 32'(count), 32'd2);
    chk("reen_busy",  32'(busy),  32'd1);

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_busy",  32'(busy),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // One-cycle tick: every cycle ends a phase.
    en1 = 1'b1;
    @(negedge clk);
    chk("t1_start_phase", 32'(phase1), 32'd0);
    chk("t1_start_tick",  32'(tick1),  32'd0);
    chk("t1_start_last",  32'(last1),  32'd1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("t1_tick",  32'(tick1), 32'd1);
      chk("t1_pd",    32'(phase_done1), 32'd1);
      chk("t1_phase", 32'(phase1), 32'(k % 3));
      chk("t1_cd",    32'(cycle_done1), (k % 3 == 0) ? 32'd1 : 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
